// File: rtl/arith_pkg.sv
// Shared arithmetic-unit definitions: divider FSM encoding, default width, counter sizing.
package arith_pkg;

  localparam int DEFAULT_WIDTH = 16;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/seq_divider_16_if.sv
// Start/busy/done request bus between the issuing controller and the divider.
interface seq_divider_16_if import arith_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_trial_sub.sv
// Trial subtract {R,Q[MSB]} - {0,D} as invert-plus-carry-in; purely combinational.
// Zero latency; no handshake.
module div_trial_sub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   minuend,
  input  logic [WIDTH:0]   subtrahend,
  output logic [WIDTH-1:0] diff,
  output logic             nonneg
);

  logic [WIDTH:0] sum;

  // R < D always holds, so the true difference lies within +/-2^WIDTH and the
  // top bit of the WIDTH+1-bit result is an exact sign bit.
  assign sum    = minuend + ~subtrahend + (WIDTH+1)'(1);
  assign diff   = sum[WIDTH-1:0];
  assign nonneg = ~sum[WIDTH];

endmodule

// File: rtl/seq_divider_16.sv
// Iterative restoring divider, one quotient bit per clock; SEQ_DIVIDER_SIGNED_DIV_EN adds two's-complement operands.
// Latency WIDTH+1 cycles (1 for divide-by-zero); start ignored while busy, no queueing.
module seq_divider_16 import arith_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  seq_divider_16_if.slave   dif
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state, state_nxt;
  logic [WIDTH-1:0] q_reg, d_reg, r_reg;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             dbz_q;

  logic [WIDTH-1:0] t_diff;
  logic             t_nonneg;
  logic [WIDTH-1:0] q_nxt, r_nxt, q_fin, r_fin;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic             accept, last_iter;

  div_trial_sub #(.WIDTH(WIDTH)) u_trial (
    .minuend    ({r_reg, q_reg[WIDTH-1]}),
    .subtrahend ({1'b0, d_reg}),
    .diff       (t_diff),
    .nonneg     (t_nonneg)
  );

  assign q_nxt     = {q_reg[WIDTH-2:0], t_nonneg};
  assign r_nxt     = t_nonneg ? t_diff : {r_reg[WIDTH-2:0], q_reg[WIDTH-1]};
  assign accept    = (state == ST_IDLE) && dif.start;
  assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
  logic neg_q, neg_r;

  assign dvd_mag = dif.dividend[WIDTH-1] ? -dif.dividend : dif.dividend;
  assign dvs_mag = dif.divisor[WIDTH-1]  ? -dif.divisor  : dif.divisor;
  // most-negative / -1 falls out naturally: the magnitude quotient negates to itself.
  assign q_fin   = neg_q ? -q_nxt : q_nxt;
  assign r_fin   = neg_r ? -r_nxt : r_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (accept) begin
      neg_q <= dif.dividend[WIDTH-1] ^ dif.divisor[WIDTH-1];
      neg_r <= dif.dividend[WIDTH-1];
    end
  end
`else
  assign dvd_mag = dif.dividend;
  assign dvs_mag = dif.divisor;
  assign q_fin   = q_nxt;
  assign r_fin   = r_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dif.busy  = 1'b0;
    dif.done  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dif.start) begin
          state_nxt = (dif.divisor != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        dif.busy = 1'b1;
        if (last_iter) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        dif.busy  = 1'b1;
        dif.done  = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg  <= '0;
      d_reg  <= '0;
      r_reg  <= '0;
      cnt    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dif.start) begin
            if (dif.divisor != '0) begin
              q_reg <= dvd_mag;
              d_reg <= dvs_mag;
              r_reg <= '0;
              cnt   <= '0;
            end else begin
              quot_q <= '1;
              rem_q  <= dif.dividend;
              dbz_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          q_reg <= q_nxt;
          r_reg <= r_nxt;
          cnt   <= cnt + CW'(1);
          if (last_iter) begin
            quot_q <= q_fin;
            rem_q  <= r_fin;
            dbz_q  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign dif.quotient    = quot_q;
  assign dif.remainder   = rem_q;
  assign dif.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_16.sv
// Directed bench for seq_divider_16: latency, results, handshake and reset behaviour.
module tb_seq_divider_16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  seq_divider_16_if #(.WIDTH(16)) dif ();

  seq_divider_16 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clk);
    #1;
    dif.start    = 1'b0;
    dif.dividend = 16'hDEAD;
    dif.divisor  = 16'h0BAD;
  endtask

  // lat = negedges after the accepting edge until done is seen; -1 on timeout
  task automatic wait_done(output int lat, output int busy_lo);
    lat     = -1;
    busy_lo = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (!dif.busy) busy_lo++;
      if (dif.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({dif.busy, dif.done, dif.div_by_zero} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags: got busy/done/dbz=%b expected 000", {dif.busy, dif.done, dif.div_by_zero});
    end
    total++;
    if ({dif.quotient, dif.remainder} !== 32'h0) begin
      bad++;
      $display("FAIL reset_results: got q=%h r=%h expected 0000 0000", dif.quotient, dif.remainder);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat, blo;
    start_op(16'd100, 16'd7);
    wait_done(lat, blo);
    total++;
    if (lat !== 17) begin bad++; $display("FAIL basic_latency: got %0d expected 17", lat); end
    total++;
    if (blo !== 0) begin bad++; $display("FAIL basic_busy: busy low in %0d cycles expected 0", blo); end
    total++;
    if (dif.quotient !== 16'd14 || dif.remainder !== 16'd2 || dif.div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b expected 14 2 0", dif.quotient, dif.remainder, dif.div_by_zero);
    end
    @(negedge clk);
    total++;
    if (dif.done !== 1'b0 || dif.busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_pulse: got done=%b busy=%b expected 0 0", dif.done, dif.busy);
    end
  endtask

  task automatic test_div_by_zero;
    int lat, blo;
    start_op(16'h1234, 16'h0000);
    wait_done(lat, blo);
    total++;
    if (lat !== 1 || blo !== 0) begin bad++; $display("FAIL dbz_latency: got lat=%0d busy_lo=%0d expected 1 0", lat, blo); end
    total++;
    if (dif.quotient !== 16'hFFFF || dif.remainder !== 16'h1234 || dif.div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL dbz_result: got q=%h r=%h dbz=%b expected ffff 1234 1", dif.quotient, dif.remainder, dif.div_by_zero);
    end
    @(negedge clk);
    total++;
    if (dif.busy !== 1'b0 || dif.div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL dbz_hold: got busy=%b dbz=%b expected 0 1", dif.busy, dif.div_by_zero);
    end
  endtask

  task automatic test_extremes;
    int lat, blo;
    logic [15:0] exp_q, exp_r;
    start_op(16'hFFFF, 16'h0001);
    wait_done(lat, blo);
    total++;
    if (lat !== 17 || dif.quotient !== 16'hFFFF || dif.remainder !== 16'h0000 || dif.div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL ext_max_by_one: got lat=%0d q=%h r=%h dbz=%b expected 17 ffff 0000 0", lat, dif.quotient, dif.remainder, dif.div_by_zero);
    end
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    exp_q = 16'hFFFB;
    exp_r = 16'h0000;
`else
    exp_q = 16'h0000;
    exp_r = 16'h0005;
`endif
    start_op(16'h0005, 16'hFFFF);
    wait_done(lat, blo);
    total++;
    if (lat !== 17 || dif.quotient !== exp_q || dif.remainder !== exp_r) begin
      bad++;
      $display("FAIL ext_small_by_max: got lat=%0d q=%h r=%h expected 17 %h %h", lat, dif.quotient, dif.remainder, exp_q, exp_r);
    end
  endtask

  task automatic test_handshake;
    int lat, blo;
    lat = -1;
    start_op(16'd50, 16'd6);
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 3 || k == 16) begin
        dif.start    = 1'b1;
        dif.dividend = 16'h00FF;
        dif.divisor  = 16'h0001;
      end else begin
        dif.start    = 1'b0;
      end
      if (dif.done) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat !== 17 || dif.quotient !== 16'd8 || dif.remainder !== 16'd2) begin
      bad++;
      $display("FAIL hs_ignore: got lat=%0d q=%0d r=%0d expected 17 8 2", lat, dif.quotient, dif.remainder);
    end
    // start raised during the done cycle and held: ignored there, taken one edge later
    dif.start    = 1'b1;
    dif.dividend = 16'd200;
    dif.divisor  = 16'd10;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (dif.busy !== 1'b0) begin bad++; $display("FAIL hs_done_ignore: got busy=%b expected 0", dif.busy); end
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_done(lat, blo);
    total++;
    if (lat !== 17 || dif.quotient !== 16'd20 || dif.remainder !== 16'd0) begin
      bad++;
      $display("FAIL hs_back_to_back: got lat=%0d q=%0d r=%0d expected 17 20 0", lat, dif.quotient, dif.remainder);
    end
  endtask

  task automatic test_reset_mid_run;
    int lat, blo, dones;
    start_op(16'd1000, 16'd3);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({dif.busy, dif.done, dif.div_by_zero} !== 3'b000 || dif.quotient !== 16'h0 || dif.remainder !== 16'h0) begin
      bad++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b dbz=%b q=%h r=%h expected all zero",
               dif.busy, dif.done, dif.div_by_zero, dif.quotient, dif.remainder);
    end
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (dif.done || dif.busy) dones++;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", dones); end
    start_op(16'd81, 16'd9);
    wait_done(lat, blo);
    total++;
    if (lat !== 17 || dif.quotient !== 16'd9 || dif.remainder !== 16'd0) begin
      bad++;
      $display("FAIL rst_mid_fresh: got lat=%0d q=%0d r=%0d expected 17 9 0", lat, dif.quotient, dif.remainder);
    end
  endtask

`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
  task automatic test_signed;
    int lat, blo;
    start_op(16'hFFF9, 16'h0002);
    wait_done(lat, blo);
    total++;
    if (lat !== 17 || dif.quotient !== 16'hFFFD || dif.remainder !== 16'hFFFF) begin
      bad++;
      $display("FAIL sgn_neg_dividend: got lat=%0d q=%h r=%h expected 17 fffd ffff", lat, dif.quotient, dif.remainder);
    end
    start_op(16'h0007, 16'hFFFE);
    wait_done(lat, blo);
    total++;
    if (lat !== 17 || dif.quotient !== 16'hFFFD || dif.remainder !== 16'h0001) begin
      bad++;
      $display("FAIL sgn_neg_divisor: got lat=%0d q=%h r=%h expected 17 fffd 0001", lat, dif.quotient, dif.remainder);
    end
    start_op(16'h8000, 16'hFFFF);
    wait_done(lat, blo);
    total++;
    if (lat !== 17 || dif.quotient !== 16'h8000 || dif.remainder !== 16'h0000) begin
      bad++;
      $display("FAIL sgn_min_by_m1: got lat=%0d q=%h r=%h expected 17 8000 0000", lat, dif.quotient, dif.remainder);
    end
  endtask
`endif

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = 16'h0;
    dif.divisor  = 16'h0;
    test_reset;
    test_basic;
    test_div_by_zero;
    test_extremes;
    test_handshake;
    test_reset_mid_run;
`ifdef SEQ_DIVIDER_SIGNED_DIV_EN
    test_signed;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_divider_16.md
Name: seq_divider_16

Overview:
- Iterative restoring unsigned divider (quotient/remainder); the inverse datapath to the team's fast multiplier/CLA adders.
- Uses one WIDTH+1-bit trial subtractor per cycle; one quotient bit resolved per clock.
- Sits beside the multiplier in the arithmetic unit; start/busy/done handshake toward the issuing controller.

Parameters:
- WIDTH, 16, operand/quotient/remainder width; legal range 4..32.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  numerator, captured on accepted start
- divisor  input  WIDTH  denominator, captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  result, held until the next accepted start
- remainder  output  WIDTH  result, held until the next accepted start
- div_by_zero  output  1  flag qualifying the current results; held with them

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0. Reset overrides everything, including mid-RUN. The operation is abandoned and done is not pulsed.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: on an edge with start=1 and divisor!=0.
  - Capture dividend into the Q shift register and divisor into D.
  - Clear the partial remainder R (WIDTH bits) and the counter.
- IDLE -> DONE: on an edge with start=1 and divisor==0.
  - quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1.
- RUN: each edge performs one iteration.
  - T = {R, Q[MSB]} - {1'b0, D}, computed at WIDTH+1 bits.
  - If T is non-negative: R = T[WIDTH-1:0] and shift 1 into Q. Otherwise R = {R[WIDTH-2:0], Q[MSB]} and shift 0 into Q.
  - Counter increments each iteration. After the WIDTH-th iteration the FSM goes to DONE, loading quotient=Q, remainder=R, div_by_zero=0.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- Latency:
  - Start accepted on edge N: done is high in the cycle after edge N+WIDTH. That is edge N+16 for the default width, a 17-cycle busy window.
  - Divide-by-zero: done is high in the cycle after edge N; busy is high for that one cycle.
- start while busy=1 is ignored (not queued). start high during the DONE cycle is ignored. A new start is accepted the cycle after done at the earliest.
- Operand inputs are don't-care except on the accepting edge.
- Invariant after completion: dividend == quotient*divisor + remainder, and remainder < divisor.
- Arithmetic is modular WIDTH-bit; no overflow is possible for unsigned operation.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at capture.
  - The unsigned core runs unchanged.
  - The quotient is negated when operand signs differ, truncating toward zero.
  - The remainder takes the dividend's sign.
  - The fixup is applied combinationally on the RUN->DONE load, so latency is unchanged.
  - Special case: most-negative / -1 gives quotient=most-negative and remainder=0.
  - Divide-by-zero gives quotient=-1 (all ones) and remainder=dividend, as in unsigned mode.
- Undefined: purely unsigned behaviour as above; no sign logic synthesised.

Decomposition:
- Shared package (arith_pkg): FSM state encoding constants (ST_IDLE, ST_RUN, ST_DONE), default WIDTH, and the counter width constant CNT_W = clog2(WIDTH+1).
- One natural sub-module: div_trial_sub.
  - Combinational WIDTH+1-bit subtract of {R, Q[MSB]} minus {1'b0, D}.
  - Outputs the difference and a non-negative flag.
  - Built on the team's carry-lookahead adder style: invert plus carry-in of 1.

Test Plan:
- Basic divide: start with dividend=100, divisor=7 -> done high 17 cycles after the start edge, quotient=14, remainder=2, div_by_zero=0; busy high for those 17 cycles.
- Divide by zero: dividend=0x1234, divisor=0 -> done in the next cycle, quotient=0xFFFF, remainder=0x1234, div_by_zero=1.
- Extreme operands:
  - 0xFFFF/0x0001 -> quotient=0xFFFF, remainder=0.
  - 0x0005/0xFFFF -> quotient=0, remainder=5.
- Handshake robustness: re-pulse start with other operands at cycles 3 and 16 of a run of 50/6 -> they are ignored and the result is 8 r 2; a back-to-back start the cycle after done is accepted.
- Reset mid-run: assert rst at cycle 8 of a run -> all outputs return to 0 next edge, no done pulse; a fresh 81/9 afterwards gives 9 r 0.
- With SEQ_DIVIDER_SIGNED_DIV_EN:
  - -7/2 -> -3 r -1.
  - 7/-2 -> -3 r 1.
  - 0x8000/0xFFFF -> 0x8000 r 0.
  - Latency is still 17 cycles.
